// File: rtl/usart_rx_frame_receiver_if.sv
// Host-side bundle of the USART receiver: UDR read strobe in, received word
// and status flags out.
//   i_udr_read      host -> rx : single-cycle pulse, host has read o_data
//   o_data          rx -> host : last received word
//   o_rx_complete   rx -> host : unread word available
//   o_frame_error   rx -> host : stop bit of o_data's frame sampled as 0
//   o_parity_error  rx -> host : parity mismatch on o_data's frame
//   o_data_overrun  rx -> host : a complete frame was dropped, o_data unread
//   o_rx_busy       rx -> host : receiver FSM is not idle
interface usart_rx_frame_receiver_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 i_udr_read;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_rx_complete;
  logic                 o_frame_error;
  logic                 o_parity_error;
  logic                 o_data_overrun;
  logic                 o_rx_busy;

  // Receiver side
  modport master (
    input  i_udr_read,
    output o_data, o_rx_complete, o_frame_error, o_parity_error,
           o_data_overrun, o_rx_busy
  );

  // Host side
  modport slave (
    output i_udr_read,
    input  o_data, o_rx_complete, o_frame_error, o_parity_error,
           o_data_overrun, o_rx_busy
  );
endinterface

// File: rtl/usart_rx_frame_receiver.sv
// USART receive frame recovery on the 16x oversampled clock.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity, stop bit.
// Each bit is decided by a 2-of-3 vote over samples at counter 7, 8, 9.
// Ports:
//   i_rxclk   receive clock (16x baud)
//   i_rst     synchronous active-high reset
//   i_rxd     serial line, already synchronised, idles high
//   i_rxen    receiver enable; low aborts any frame in progress
//   i_upm1    parity enable
//   i_upm0    parity mode (0 even, 1 odd)
//   udr       host-side bundle (read strobe, data word, status flags)
module usart_rx_frame_receiver #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                          i_rxclk,
  input  logic                          i_rst,
  input  logic                          i_rxd,
  input  logic                          i_rxen,
  input  logic                          i_upm1,
  input  logic                          i_upm0,
  usart_rx_frame_receiver_if.master     udr
);

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned BIT_CNT_W = 4;

  localparam logic [CNT_W-1:0]     CNT_S7   = CNT_W'(7);
  localparam logic [CNT_W-1:0]     CNT_S8   = CNT_W'(8);
  localparam logic [CNT_W-1:0]     CNT_S9   = CNT_W'(9);
  localparam logic [CNT_W-1:0]     CNT_END  = CNT_W'(15);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_CHECK,
    RECEIVE_DATA,
    PARITY_CHECK,
    STOP_CHECK
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   prev_rxd_q, prev_rxd_d;
  logic                   s7_q, s7_d;
  logic                   s8_q, s8_d;
  logic                   perr_q, perr_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   rx_complete_q, rx_complete_d;
  logic                   frame_error_q, frame_error_d;
  logic                   parity_error_q, parity_error_d;
  logic                   data_overrun_q, data_overrun_d;
  logic                   rx_busy_q, rx_busy_d;

  logic                   maj_c;
  logic                   complete_c;

  // 2-of-3 vote; the third sample is the live line in the counter = 9 cycle
  assign maj_c = (s7_q & s8_q) | (s7_q & i_rxd) | (s8_q & i_rxd);

  // Next-state, datapath and status update
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    prev_rxd_d     = prev_rxd_q;
    s7_d           = s7_q;
    s8_d           = s8_q;
    perr_d         = perr_q;
    data_d         = data_q;
    rx_complete_d  = rx_complete_q;
    frame_error_d  = frame_error_q;
    parity_error_d = parity_error_q;
    data_overrun_d = data_overrun_q;
    complete_c     = 1'b0;

    if (state_q == IDLE) begin
      prev_rxd_d = i_rxd;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_S7) s7_d = i_rxd;
      if (cnt_q == CNT_S8) s8_d = i_rxd;
    end

    case (state_q)
      IDLE: begin
        if (prev_rxd_q && !i_rxd) begin
          state_d = START_CHECK;
          cnt_d   = '0;
        end
      end
      START_CHECK: begin
        if (cnt_q == CNT_S9 && maj_c) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_END) begin
          state_d   = RECEIVE_DATA;
          bit_cnt_d = '0;
        end
      end
      RECEIVE_DATA: begin
        if (cnt_q == CNT_S9) shift_d = {maj_c, shift_q[DATA_BITS-1:1]};
        if (cnt_q == CNT_END) begin
          if (bit_cnt_q == LAST_BIT) begin
            // Cleared here so a parity-less frame reports no parity error
            perr_d  = 1'b0;
            state_d = i_upm1 ? PARITY_CHECK : STOP_CHECK;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      PARITY_CHECK: begin
        if (cnt_q == CNT_S9) perr_d = (^shift_q) ^ maj_c ^ i_upm0;
        if (cnt_q == CNT_END) state_d = STOP_CHECK;
      end
      STOP_CHECK: begin
        // Frame ends mid stop bit so a back-to-back start edge is not missed
        if (cnt_q == CNT_S9) begin
          complete_c = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!i_rxen) begin
      state_d    = IDLE;
      complete_c = 1'b0;
    end

    // A read in the completion cycle frees UDR for the new word
    if (complete_c) begin
      if (!rx_complete_q || udr.i_udr_read) begin
        data_d         = shift_q;
        frame_error_d  = ~maj_c;
        parity_error_d = perr_q;
        rx_complete_d  = 1'b1;
        data_overrun_d = 1'b0;
      end else begin
        data_overrun_d = 1'b1;
      end
    end else if (udr.i_udr_read) begin
      rx_complete_d  = 1'b0;
      data_overrun_d = 1'b0;
    end

    rx_busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge i_rxclk) begin
    if (i_rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      prev_rxd_q     <= 1'b1;
      s7_q           <= 1'b0;
      s8_q           <= 1'b0;
      perr_q         <= 1'b0;
      data_q         <= '0;
      rx_complete_q  <= 1'b0;
      frame_error_q  <= 1'b0;
      parity_error_q <= 1'b0;
      data_overrun_q <= 1'b0;
      rx_busy_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      prev_rxd_q     <= prev_rxd_d;
      s7_q           <= s7_d;
      s8_q           <= s8_d;
      perr_q         <= perr_d;
      data_q         <= data_d;
      rx_complete_q  <= rx_complete_d;
      frame_error_q  <= frame_error_d;
      parity_error_q <= parity_error_d;
      data_overrun_q <= data_overrun_d;
      rx_busy_q      <= rx_busy_d;
    end
  end

  assign udr.o_data         = data_q;
  assign udr.o_rx_complete  = rx_complete_q;
  assign udr.o_frame_error  = frame_error_q;
  assign udr.o_parity_error = parity_error_q;
  assign udr.o_data_overrun = data_overrun_q;
  assign udr.o_rx_busy      = rx_busy_q;

endmodule
